// File: rtl/hold_pulse_gen.sv
// Multi-channel hold-qualified one-shot pulse generator.
// Each channel fires a programmable-width pulse once (in & data) has held for hold_len clocks.

module hold_pulse_gen_ch #(
    parameter int CNT_W = 8,
    parameter int PW_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cond,
    input  logic [CNT_W-1:0] hold_len,
    input  logic [PW_W-1:0]  pulse_len,
    input  logic             rearm,
    input  logic             clear,
    output logic             out,
    output logic             fired,
    output logic             out_nxt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        LOCK     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] H_ONE = CNT_W'(1);
    localparam logic [PW_W-1:0]  P_ONE = PW_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [PW_W-1:0]  pcnt_q, pcnt_d;
    logic [PW_W-1:0]  plen_q, plen_d;
    logic             out_q, out_d;
    logic             fired_q, fired_d;

    logic [CNT_W-1:0] hold_m1;
    logic [PW_W-1:0]  p_eff;
    logic [PW_W-1:0]  plen_m1;

    // Zero lengths behave as one; hold_len is used live every cycle.
    assign hold_m1 = (hold_len == '0) ? '0 : hold_len - H_ONE;
    assign p_eff   = (pulse_len == '0) ? P_ONE : pulse_len;
    assign plen_m1 = plen_q - P_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            plen_q  <= P_ONE;
            out_q   <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            plen_q  <= plen_d;
            out_q   <= out_d;
            fired_q <= fired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        plen_d  = plen_q;
        out_d   = out_q;
        fired_d = fired_q;
        if (clear) begin
            state_d = IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
            out_d   = 1'b0;
            fired_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cond) begin
                        hcnt_d = '0;
                    end else if (hcnt_q >= hold_m1) begin
                        state_d = PULSE;
                        out_d   = 1'b1;
                        fired_d = 1'b1;
                        pcnt_d  = '0;
                        hcnt_d  = '0;
                        plen_d  = p_eff;
                    end else if (hcnt_q != '1) begin
                        hcnt_d = hcnt_q + H_ONE;
                    end
                end
                PULSE: begin
                    // Width comes from the value latched at fire time.
                    if (pcnt_q == plen_m1) begin
                        out_d   = 1'b0;
                        state_d = rearm ? WAIT_LOW : LOCK;
                    end else begin
                        pcnt_d = pcnt_q + P_ONE;
                    end
                end
                LOCK: begin
                    out_d = 1'b0;
                end
                WAIT_LOW: begin
                    out_d = 1'b0;
                    if (!cond) begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out     = out_q;
        fired   = fired_q;
        out_nxt = out_d;
    end

endmodule

module hold_pulse_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int PW_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] data,
    input  logic [CNT_W-1:0]    hold_len,
    input  logic [PW_W-1:0]     pulse_len,
    input  logic                rearm,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] fired,
    output logic                any_out
);

    logic [CHANNELS-1:0] cond;
    logic [CHANNELS-1:0] out_nxt;

    assign cond = in & data;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        hold_pulse_gen_ch #(
            .CNT_W(CNT_W),
            .PW_W (PW_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cond     (cond[i]),
            .hold_len (hold_len),
            .pulse_len(pulse_len),
            .rearm    (rearm),
            .clear    (clear[i]),
            .out      (out[i]),
            .fired    (fired[i]),
            .out_nxt  (out_nxt[i])
        );
    end

    // Built from next-state outs so it lands on the same edge as out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_out <= 1'b0;
        else       any_out <= |out_nxt;
    end

endmodule

// File: tb/tb_hold_pulse_gen.sv
// Directed self-checking bench for hold_pulse_gen (4 channels, 8-bit hold, 4-bit pulse).
module tb_hold_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cin, cdata, clear;
    logic [7:0] hold_len;
    logic [3:0] pulse_len;
    logic       rearm;
    logic [3:0] out, fired;
    logic       any_out;

    int n_assert = 0;
    int n_fail   = 0;

    hold_pulse_gen #(.CHANNELS(4), .CNT_W(8), .PW_W(4)) dut (
        .clk(clk), .reset(reset), .in(cin), .data(cdata),
        .hold_len(hold_len), .pulse_len(pulse_len), .rearm(rearm),
        .clear(clear), .out(out), .fired(fired), .any_out(any_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        cin = '0; cdata = '0; clear = '1;
        tick();
        clear = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cin = '0; cdata = '0; clear = '0;
        hold_len = 8'd4; pulse_len = 4'd2; rearm = 1'b0;
        #12;
        n_assert++;
        if (out !== 4'b0 || fired !== 4'b0 || any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out=%b fired=%b any=%b exp 0000/0000/0", out, fired, any_out);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_legacy();
        logic exp;
        clear_all();
        rearm = 1'b0; hold_len = 8'd4; pulse_len = 4'd2;
        cin = 4'b0001; cdata = 4'b0001;
        for (int e = 1; e <= 26; e++) begin
            tick();
            exp = (e == 4 || e == 5);
            n_assert++;
            if (out[0] !== exp || any_out !== exp) begin
                n_fail++;
                $display("FAIL legacy e%0d out0=%b any=%b exp=%b", e, out[0], any_out, exp);
            end
        end
        n_assert++;
        if (fired !== 4'b0001) begin
            n_fail++;
            $display("FAIL legacy_fired fired=%b exp=0001", fired);
        end
    endtask

    task automatic test_glitch();
        clear_all();
        rearm = 1'b0; hold_len = 8'd5; pulse_len = 4'd1;
        cin = 4'b0001;
        for (int e = 1; e <= 9; e++) begin
            cdata = (e == 4) ? 4'b0000 : 4'b0001;
            tick();
            n_assert++;
            if (out[0] !== (e == 9)) begin
                n_fail++;
                $display("FAIL glitch e%0d out0=%b exp=%b", e, out[0], (e == 9));
            end
        end
        tick();
        n_assert++;
        if (out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_fall out0=%b exp=0", out[0]);
        end
    endtask

    task automatic test_rearm();
        logic exp;
        clear_all();
        rearm = 1'b1; hold_len = 8'd2; pulse_len = 4'd3;
        cin = 4'b0001; cdata = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = (e >= 2 && e <= 4);
            n_assert++;
            if (out[0] !== exp) begin
                n_fail++;
                $display("FAIL rearm_first e%0d out0=%b exp=%b", e, out[0], exp);
            end
        end
        // one low edge, then hold again: fires on 2nd high edge, 3 cycles wide
        for (int e = 0; e <= 5; e++) begin
            cdata = (e == 0) ? 4'b0000 : 4'b0001;
            tick();
            exp = (e >= 2 && e <= 4);
            n_assert++;
            if (out[0] !== exp) begin
                n_fail++;
                $display("FAIL rearm_second e%0d out0=%b exp=%b", e, out[0], exp);
            end
        end
    endtask

    task automatic test_zero_cfg();
        clear_all();
        rearm = 1'b0; hold_len = 8'd0; pulse_len = 4'd0;
        cin = 4'b0001; cdata = 4'b0001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_assert++;
            if (out[0] !== (e == 1)) begin
                n_fail++;
                $display("FAIL zero_cfg e%0d out0=%b exp=%b", e, out[0], (e == 1));
            end
        end
    endtask

    task automatic test_clear();
        clear_all();
        rearm = 1'b0; hold_len = 8'd2; pulse_len = 4'd4;
        cin = 4'b0010; cdata = 4'b0010;
        tick(); tick(); tick();
        n_assert++;
        if (out[1] !== 1'b1 || fired[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre out1=%b fired1=%b exp 1/1", out[1], fired[1]);
        end
        clear = 4'b0010;
        tick();
        clear = '0;
        n_assert++;
        if (out[1] !== 1'b0 || fired[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_edge out1=%b fired1=%b exp 0/0", out[1], fired[1]);
        end
        tick();
        n_assert++;
        if (out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_count1 out1=%b exp=0", out[1]);
        end
        tick();
        n_assert++;
        if (out[1] !== 1'b1 || fired[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_refire out1=%b fired1=%b exp 1/1", out[1], fired[1]);
        end
    endtask

    task automatic test_async_reset();
        clear_all();
        rearm = 1'b0; hold_len = 8'd1; pulse_len = 4'd4;
        cin = 4'b0001; cdata = 4'b0001;
        tick();
        n_assert++;
        if (out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre out0=%b exp=1", out[0]);
        end
        #2 reset = 1'b1;
        #1;
        n_assert++;
        if (out !== 4'b0 || fired !== 4'b0 || any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL areset out=%b fired=%b any=%b exp 0000/0000/0", out, fired, any_out);
        end
        #1 reset = 1'b0;
        cin = '0; cdata = '0;
    endtask

    task automatic test_saturation();
        clear_all();
        rearm = 1'b0; hold_len = 8'hFF; pulse_len = 4'd1;
        cin = 4'b0100; cdata = 4'b0100;
        for (int e = 1; e <= 256; e++) begin
            tick();
            n_assert++;
            if (out[2] !== (e == 255)) begin
                n_fail++;
                $display("FAIL saturation e%0d out2=%b exp=%b", e, out[2], (e == 255));
            end
        end
    endtask

    task automatic test_live_hold();
        clear_all();
        rearm = 1'b0; hold_len = 8'd10; pulse_len = 4'd1;
        cin = 4'b0001; cdata = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            if (e == 6) hold_len = 8'd3;
            tick();
            n_assert++;
            if (out[0] !== (e == 6)) begin
                n_fail++;
                $display("FAIL live_hold e%0d out0=%b exp=%b", e, out[0], (e == 6));
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] exp;
        clear_all();
        rearm = 1'b0; hold_len = 8'd3; pulse_len = 4'd2;
        // ch1 has in without data, ch2 data without in: neither may count
        cin = 4'b0011; cdata = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            if (e == 3) begin
                cin[3] = 1'b1; cdata[3] = 1'b1;
            end
            tick();
            exp = '0;
            exp[0] = (e == 3 || e == 4);
            exp[3] = (e == 5 || e == 6);
            n_assert++;
            if (out !== exp || any_out !== (|exp)) begin
                n_fail++;
                $display("FAIL multi e%0d out=%b any=%b exp=%b/%b", e, out, any_out, exp, (|exp));
            end
        end
        n_assert++;
        if (fired !== 4'b1001) begin
            n_fail++;
            $display("FAIL multi_fired fired=%b exp=1001", fired);
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_glitch();
        test_rearm();
        test_zero_cfg();
        test_clear();
        test_async_reset();
        test_saturation();
        test_live_hold();
        test_multi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
